ethernetsystem_switch_pio: RTL

// - Parametrised Avalon-MM input PIO for board switches/buttons; successor to the fixed 4-bit switch port.
// - Synchronises and debounces WIDTH inputs, then detects edges into a sticky capture register.
// - Raises a level IRQ for captured edges that are unmasked. Sits on the Ethernet system Avalon bus as a slave.

---
 rtl/ethernetsystem_switch_pio_pkg.sv | 16 +
 rtl/ethernetsystem_switch_pio_if.sv | 15 +
 rtl/ethernetsystem_switch_pio_debounce.sv | 68 ++++++
 rtl/ethernetsystem_switch_pio.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ethernetsystem_switch_pio_pkg.sv
// Shared constants for the switch/button input PIO.
// Holds the register map, the edge-type encodings and the Avalon bus widths.
package ethernetsystem_pio_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_MASK    = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/ethernetsystem_switch_pio_if.sv
// Avalon-MM slave bus for the switch PIO.
// Ports: address, chipselect, write_n, writedata (master -> slave); readdata (slave -> master).
interface ethernetsystem_switch_pio_if;
    import ethernetsystem_pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/ethernetsystem_switch_pio_debounce.sv
// One input bit: metastability chain, debounce counter and debounced state flop.
// Ports: clk, reset_n (sync, active low), primed (normal operation), prime_load
// (load the synchronised value directly), din (async input), deb (debounced level).
module switch_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic primed,
    input  logic prime_load,
    input  logic din,
    output logic deb
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    // Synchroniser shift register; the last stage is the usable sample.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // No filtering: follow the synchronised input once primed.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    deb <= 1'b0;
                end else if (primed || prime_load) begin
                    deb <= s;
                end
            end
        end else begin : g_count
            localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;

            // Accept a new level only after it differs for DEBOUNCE_CYCLES samples in a row.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                    deb   <= 1'b0;
                end else if (!primed) begin
                    cnt_q <= '0;
                    if (prime_load) begin
                        deb <= s;
                    end
                end else if (s == deb) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_q <= '0;
                    deb   <= s;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/ethernetsystem_switch_pio.sv
// Avalon-MM input PIO for board switches/buttons with debounce, edge capture and IRQ.
// Ports: clk, reset_n (sync, active low), bus (Avalon slave: address, chipselect,
// write_n, writedata, readdata), in_port (async inputs), irq (level interrupt).
module ethernetsystem_switch_pio
    import ethernetsystem_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned EDGE_TYPE       = EDGE_RISING
) (
    input  logic                         clk,
    input  logic                         reset_n,
    ethernetsystem_switch_pio_if.slave   bus,
    input  logic [WIDTH-1:0]             in_port,
    output logic                         irq
);

    localparam int unsigned PRIME_W = $clog2(SYNC_STAGES + 1);
    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(SYNC_STAGES);

    logic [PRIME_W-1:0] prime_cnt_q;
    logic               primed_q;
    logic               edge_en_q;
    logic               prime_load_c;

    logic [WIDTH-1:0]   deb;
    logic [WIDTH-1:0]   deb_prev_q;
    logic [WIDTH-1:0]   capture_q;
    logic [WIDTH-1:0]   mask_q;

    logic [WIDTH-1:0]   edge_c;
    logic [WIDTH-1:0]   w1c_c;
    logic [WIDTH-1:0]   capture_next_c;
    logic [WIDTH-1:0]   mask_next_c;
    logic [DATA_W-1:0]  rdata_c;
    logic               wr_c;
    logic               unused_wdata_c;

    // Priming waits for the synchroniser to fill, then loads the debounced state once.
    assign prime_load_c = !primed_q && (prime_cnt_q == PRIME_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prime_cnt_q <= '0;
            primed_q    <= 1'b0;
            edge_en_q   <= 1'b0;
        end else begin
            if (!primed_q) begin
                if (prime_load_c) begin
                    primed_q <= 1'b1;
                end else begin
                    prime_cnt_q <= prime_cnt_q + PRIME_W'(1);
                end
            end
            // Edge detect starts one cycle after priming so the initial load is not an edge.
            edge_en_q <= primed_q;
        end
    end

    // Per-bit synchroniser and debouncer.
    generate
        for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
            switch_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk        (clk),
                .reset_n    (reset_n),
                .primed     (primed_q),
                .prime_load (prime_load_c),
                .din        (in_port[i]),
                .deb        (deb[i])
            );
        end
    endgenerate

    assign wr_c           = bus.chipselect && !bus.write_n;
    assign unused_wdata_c = ^bus.writedata;

    // Edge select, write decode and next-state for capture/mask.
    always_comb begin
        edge_c = '0;
        if (edge_en_q) begin
            if (EDGE_TYPE == EDGE_RISING) begin
                edge_c = deb & ~deb_prev_q;
            end else if (EDGE_TYPE == EDGE_FALLING) begin
                edge_c = ~deb & deb_prev_q;
            end else begin
                edge_c = deb ^ deb_prev_q;
            end
        end

        w1c_c = '0;
        if (wr_c && (bus.address == ADDR_EDGECAP)) begin
            w1c_c = bus.writedata[WIDTH-1:0];
        end

        // A new edge wins over a simultaneous clear.
        capture_next_c = (capture_q & ~w1c_c) | edge_c;

        mask_next_c = mask_q;
        if (wr_c && (bus.address == ADDR_MASK)) begin
            mask_next_c = bus.writedata[WIDTH-1:0];
        end
    end

    // Read mux, sampled every cycle regardless of chipselect.
    always_comb begin
        rdata_c = '0;
        case (bus.address)
            ADDR_DATA:    rdata_c = DATA_W'(deb);
            ADDR_MASK:    rdata_c = DATA_W'(mask_q);
            ADDR_EDGECAP: rdata_c = DATA_W'(capture_q);
            default:      rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            deb_prev_q   <= '0;
            capture_q    <= '0;
            mask_q       <= '0;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            deb_prev_q   <= deb;
            capture_q    <= capture_next_c;
            mask_q       <= mask_next_c;
            irq          <= |(capture_next_c & mask_next_c);
            bus.readdata <= rdata_c;
        end
    end

endmodule
